// File: rtl/dm_responder_if.sv
// MEM-stage data-memory bus: the control unit (master) drives address/data/strobe,
// the responder (slave) returns combinational load data and an access-error flag.
interface dm_responder_if;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [2:0]  mem_op;
  logic [31:0] rdata;
  logic        addr_err;

  modport master (
    output pc, addr, wdata, mem_write, mem_op,
    input  rdata, addr_err
  );

  modport slave (
    input  pc, addr, wdata, mem_write, mem_op,
    output rdata, addr_err
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: word/half/byte stores on the clock edge, combinational extended loads.
// Optional macro DM_LOG_EN prints one line per committed store.
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE        = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    dm_responder_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [2:0] {
        OP_W  = 3'd0,
        OP_H  = 3'd1,
        OP_HU = 3'd2,
        OP_B  = 3'd3,
        OP_BU = 3'd4
    } mem_op_e;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] offset;
    logic [31:0] widx;
    logic        in_range;
    logic        fmt_err;
    logic        err;
    logic [31:0] word_rd;
    logic [31:0] wr_word_d;
    logic [31:0] load_val;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic        wr_en;

    always_comb begin
        offset   = bus.addr - BASE;
        widx     = offset >> 2;
        // Below-BASE addresses wrap to huge offsets, but are rejected explicitly too.
        in_range = (bus.addr >= BASE) && (widx < DEPTH_WORDS);
        word_rd  = in_range ? mem_q[widx[IDX_W-1:0]] : '0;

        fmt_err = 1'b0;
        case (bus.mem_op)
            OP_W:        fmt_err = (bus.addr[1:0] != 2'b00);
            OP_H, OP_HU: fmt_err = bus.addr[0];
            OP_B, OP_BU: fmt_err = 1'b0;
            default:     fmt_err = 1'b1;
        endcase
        err   = !in_range || fmt_err;
        wr_en = bus.mem_write && !err;

        half_v = bus.addr[1] ? word_rd[31:16] : word_rd[15:0];
        case (bus.addr[1:0])
            2'd0:    byte_v = word_rd[7:0];
            2'd1:    byte_v = word_rd[15:8];
            2'd2:    byte_v = word_rd[23:16];
            default: byte_v = word_rd[31:24];
        endcase

        wr_word_d = word_rd;
        load_val  = '0;
        case (bus.mem_op)
            OP_W: begin
                wr_word_d = bus.wdata;
                load_val  = word_rd;
            end
            OP_H, OP_HU: begin
                if (bus.addr[1]) wr_word_d[31:16] = bus.wdata[15:0];
                else             wr_word_d[15:0]  = bus.wdata[15:0];
                load_val = (bus.mem_op == OP_H) ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
            end
            OP_B, OP_BU: begin
                case (bus.addr[1:0])
                    2'd0:    wr_word_d[7:0]   = bus.wdata[7:0];
                    2'd1:    wr_word_d[15:8]  = bus.wdata[7:0];
                    2'd2:    wr_word_d[23:16] = bus.wdata[7:0];
                    default: wr_word_d[31:24] = bus.wdata[7:0];
                endcase
                load_val = (bus.mem_op == OP_B) ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
            end
            default: begin
                wr_word_d = word_rd;
                load_val  = '0;
            end
        endcase
    end

    assign bus.rdata    = err ? '0 : load_val;
    assign bus.addr_err = err;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[widx[IDX_W-1:0]] <= wr_word_d;
`ifdef DM_LOG_EN
            $display("%0t@%08h: *%08h <= %08h", $time, bus.pc, {bus.addr[31:2], 2'b00}, wr_word_d);
`else
`endif
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// Directed-vector bench for dm_responder: driver pushes expected load results into a queue,
// a negedge monitor pops and compares against the live outputs.
module tb_dm_responder;
    logic clk = 1'b0;
    logic reset;

    dm_responder_if bus ();

    dm_responder #(.DEPTH_WORDS(3072), .BASE(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Drive one cycle just after the rising edge; queue the expectation for this cycle.
    task automatic step(input logic rst, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic chk, input string name,
                        input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        reset         = rst;
        bus.mem_write = we;
        bus.mem_op    = op;
        bus.addr      = addr;
        bus.wdata     = wdata;
        bus.pc        = 32'h0040_0000 + addr;
        if (chk) begin
            e.name  = name;
            e.rdata = exp_rd;
            e.err   = exp_err;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (bus.rdata !== e.rdata) begin
                n_fail++;
                $display("FAIL %s rdata: got %08h expected %08h", e.name, bus.rdata, e.rdata);
            end
            n_tests++;
            if (bus.addr_err !== e.err) begin
                n_fail++;
                $display("FAIL %s addr_err: got %b expected %b", e.name, bus.addr_err, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; bus.mem_write = 1'b0; bus.mem_op = 3'd0;
        bus.addr = '0; bus.wdata = '0; bus.pc = '0;
        @(posedge clk); #1;
        step(1, 0, 3'd0, 32'h0000_0000, 32'h0, 0, "", 32'h0, 1'b0);

        // reset sweep
        step(0, 0, 3'd0, 32'h0000_0000, 32'h0, 1, "lw_0x0",    32'h0, 1'b0);
        step(0, 0, 3'd0, 32'h0000_0004, 32'h0, 1, "lw_0x4",    32'h0, 1'b0);
        step(0, 0, 3'd0, 32'h0000_2FFC, 32'h0, 1, "lw_0x2ffc", 32'h0, 1'b0);

        // word store: same-cycle read sees old value
        step(0, 1, 3'd0, 32'h0000_0010, 32'h1234_5678, 1, "sw_same_cycle", 32'h0, 1'b0);
        step(0, 0, 3'd0, 32'h0000_0010, 32'h0, 1, "lw_after_sw", 32'h1234_5678, 1'b0);

        // sub-word merges (same-cycle reads return old lane)
        step(0, 1, 3'd3, 32'h0000_0011, 32'hFFFF_FFAB, 1, "sb_0x11_old", 32'h0000_0056, 1'b0);
        step(0, 1, 3'd1, 32'h0000_0012, 32'h0000_BEEF, 1, "sh_0x12_old", 32'h0000_1234, 1'b0);
        step(0, 0, 3'd0, 32'h0000_0010, 32'h0, 1, "lw_merged",  32'hBEEF_AB78, 1'b0);
        step(0, 0, 3'd3, 32'h0000_0011, 32'h0, 1, "lb_0x11",    32'hFFFF_FFAB, 1'b0);
        step(0, 0, 3'd4, 32'h0000_0011, 32'h0, 1, "lbu_0x11",   32'h0000_00AB, 1'b0);
        step(0, 0, 3'd1, 32'h0000_0012, 32'h0, 1, "lh_0x12",    32'hFFFF_BEEF, 1'b0);
        step(0, 0, 3'd2, 32'h0000_0010, 32'h0, 1, "lhu_0x10",   32'h0000_AB78, 1'b0);
        step(0, 0, 3'd4, 32'h0000_0013, 32'h0, 1, "lbu_0x13",   32'h0000_00BE, 1'b0);
        step(0, 0, 3'd3, 32'h0000_0010, 32'h0, 1, "lb_0x10",    32'h0000_0078, 1'b0);
        step(0, 0, 3'd1, 32'h0000_0010, 32'h0, 1, "lh_0x10",    32'hFFFF_AB78, 1'b0);

        // illegal accesses: flagged, zero data, no state change
        step(0, 1, 3'd0, 32'h0000_0013, 32'hFFFF_FFFF, 1, "sw_misalign",  32'h0, 1'b1);
        step(0, 1, 3'd1, 32'h0000_0011, 32'hFFFF_FFFF, 1, "sh_misalign",  32'h0, 1'b1);
        step(0, 1, 3'd0, 32'h0000_3000, 32'hFFFF_FFFF, 1, "sw_oob",       32'h0, 1'b1);
        step(0, 1, 3'd6, 32'h0000_0010, 32'hFFFF_FFFF, 1, "op6",          32'h0, 1'b1);
        step(0, 0, 3'd2, 32'h0000_0013, 32'h0,         1, "lhu_misalign", 32'h0, 1'b1);
        step(0, 0, 3'd4, 32'h8000_0000, 32'h0,         1, "lbu_far_oob",  32'h0, 1'b1);
        step(0, 0, 3'd0, 32'h0000_0010, 32'h0, 1, "lw_unchanged", 32'hBEEF_AB78, 1'b0);
        step(0, 0, 3'd0, 32'h0000_0000, 32'h0, 1, "lw_no_wrap",   32'h0, 1'b0);

        // highest legal word
        step(0, 1, 3'd0, 32'h0000_2FFC, 32'hCAFE_F00D, 1, "sw_top_old", 32'h0, 1'b0);
        step(0, 0, 3'd0, 32'h0000_2FFC, 32'h0, 1, "lw_top", 32'hCAFE_F00D, 1'b0);

        // back-to-back byte stores build a word
        step(0, 1, 3'd4, 32'h0000_0040, 32'h0000_0011, 1, "sb_l0", 32'h0, 1'b0);
        step(0, 1, 3'd4, 32'h0000_0041, 32'h0000_0022, 1, "sb_l1", 32'h0, 1'b0);
        step(0, 1, 3'd4, 32'h0000_0042, 32'h0000_0033, 1, "sb_l2", 32'h0, 1'b0);
        step(0, 1, 3'd4, 32'h0000_0043, 32'h0000_0044, 1, "sb_l3", 32'h0, 1'b0);
        step(0, 0, 3'd0, 32'h0000_0040, 32'h0, 1, "lw_built", 32'h4433_2211, 1'b0);

        // reset beats a same-cycle store and clears earlier stores
        step(1, 1, 3'd0, 32'h0000_0020, 32'hFFFF_FFFF, 1, "rst_sw_cycle", 32'h0, 1'b0);
        step(0, 0, 3'd0, 32'h0000_0020, 32'h0, 1, "lw_after_rst",  32'h0, 1'b0);
        step(0, 0, 3'd0, 32'h0000_0010, 32'h0, 1, "lw_0x10_clr",   32'h0, 1'b0);
        step(0, 0, 3'd0, 32'h0000_2FFC, 32'h0, 1, "lw_top_clr",    32'h0, 1'b0);
        step(0, 0, 3'd0, 32'h0000_0040, 32'h0, 1, "lw_0x40_clr",   32'h0, 1'b0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the MEM stage of the five-stage MIPS pipeline: the storage end of the memory interface that the MEM-stage control unit drives. It accepts the stage's byte address, store data and write strobe. It performs word, halfword and byte stores on the clock edge and returns combinational, sign- or zero-extended load data. Misaligned and out-of-range accesses are flagged and suppressed.

## Interface
Parameters:
- DEPTH_WORDS, 3072: number of 32-bit words; valid byte range is BASE to BASE+4*DEPTH_WORDS-1.
- BASE, 32'h0000_0000: byte address of word 0; must be word aligned.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears every word to 0.
- pc  in  32  PC of the instruction in MEM, used only for the write log.
- addr  in  32  byte address (ALU result carried into MEM).
- wdata  in  32  store data (forwarded rt value); low bits used for sh/sb.
- mem_write  in  1  store strobe from the MEM-stage control unit.
- mem_op  in  3  access size/extension: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned; 5–7 reserved.
- rdata  out  32  load result, combinational.
- addr_err  out  1  access is illegal, combinational.

## Operation
- Word index = (addr − BASE) >> 2; byte lane = addr[1:0].
- addr_err = 1 when: addr < BASE or index ≥ DEPTH_WORDS; or mem_op 0 with addr[1:0] ≠ 0; or mem_op 1/2 with addr[0] ≠ 0; or mem_op 5–7. It is evaluated regardless of mem_write.
- Store (mem_write=1, addr_err=0): merge into the addressed word.
  - op 0: whole wdata.
  - op 1/2: wdata[15:0] into lane addr[1] (0 → bits 15:0, 1 → bits 31:16).
  - op 3/4: wdata[7:0] into bits 8·addr[1:0]+7 : 8·addr[1:0].
  - Untouched bytes keep their value.
- Store with addr_err=1: no state change, no log line.
- Load, always driven:
  - op 0: the word.
  - op 1: the selected halfword, sign-extended. op 2: zero-extended.
  - op 3: the selected byte, sign-extended. op 4: zero-extended.
  - rdata = 0 whenever addr_err=1.
- Little-endian lanes: byte 0 = bits 7:0.

## Timing
- Reset: on a rising edge with reset=1, all words become 0. Reset beats mem_write in the same cycle; the store is dropped and not logged. Reset asserted in the middle of a store sequence discards only the store in that cycle; earlier stores are also cleared by the reset.
- After reset: rdata = 0 for any legal address; addr_err follows its inputs (combinational, no reset value).
- Store latency: the word updates at the rising edge that samples mem_write=1. A load of the same address in the same cycle returns the old contents; the next cycle returns the merged word.
- Load latency: 0 cycles (combinational from addr, mem_op and array state).
- Back-to-back stores to the same word on consecutive cycles: each merges onto the result of the previous one, so sb to lanes 0..3 on four cycles builds the full word.
- Highest legal word (index DEPTH_WORDS−1) is writable. Index DEPTH_WORDS flags addr_err; it never wraps to word 0.

## Configuration
- DM_LOG_EN defined: every committed store prints one line at the write edge, "<time>@<pc, 8 hex>: *<word-aligned byte addr, 8 hex> <= <full merged word, 8 hex>". Suppressed and reset-dropped stores print nothing.
- DM_LOG_EN undefined: no display statements compiled; storage behaviour is identical.

## Test plan
- Reset then load sweep: assert reset 1 cycle; lw at 0x0, 0x4, 0x2FFC → rdata 0, addr_err 0.
- Word store/load: sw 0x12345678 to 0x10; same-cycle lw → 0; next-cycle lw → 0x12345678. With DM_LOG_EN, one log line "*00000010 <= 12345678".
- Sub-word merge: after the previous store, sb 0xAB at 0x11, then sh 0xBEEF at 0x12 → word 0xBEEFAB78. lb 0x11 → 0xFFFFFFAB; lbu 0x11 → 0x000000AB; lh 0x12 → 0xFFFFBEEF; lhu 0x10 → 0x0000AB78.
- Illegal accesses: sw to 0x13, sh to 0x11, sw to 0x3000 (DEPTH 3072), mem_op 6 → addr_err 1, rdata 0, memory unchanged, no log.
- Reset priority: mem_write=1 and reset=1 on the same edge with sw 0xFFFFFFFF to 0x20 → next-cycle lw 0x20 = 0, no log line.
